// File: rtl/dotp_pkg.sv
// Shared definitions for the dot-product datapath: default sizes,
// the vector store state encoding and a constant-friendly clog2.
package dotp_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_VEC_LEN    = 4;
  localparam int DEF_NUM_VEC    = 4;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vec_stream_mem_if.sv
// Bus bundle for the vector store: element write port, vector read
// request and the valid/ready element stream towards the MAC stage.
interface vec_stream_mem_if
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int VEC_LEN    = DEF_VEC_LEN,
  parameter int NUM_VEC    = DEF_NUM_VEC
);

  localparam int DEPTH      = NUM_VEC * VEC_LEN;
  localparam int ADDR_WIDTH = clog2(DEPTH);
  localparam int VEC_WIDTH  = clog2(NUM_VEC);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;
  logic [VEC_WIDTH-1:0]  rd_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  init_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_vec, out_ready,
    input  out_valid, out_data, out_last, busy, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_vec, out_ready,
    output out_valid, out_data, out_last, busy, init_done
  );

endinterface

// File: rtl/vec_ram_1r1w.sv
// Simple dual-port synchronous RAM: one write port, one registered read
// port with read enable. Same-address read and write in one cycle returns
// the old contents. The array itself is not reset.
module vec_ram_1r1w
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = clog2(DEF_NUM_VEC * DEF_VEC_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Read data only moves when a read is issued, otherwise it holds.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Output register, cleared by reset so the stream data starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vec_stream_mem.sv
// Vector store for the dot-product datapath. Zero-fills itself after
// reset, accepts single-element writes and streams one whole vector per
// request over valid/ready with backpressure.
module vec_stream_mem
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int VEC_LEN    = DEF_VEC_LEN,
  parameter int NUM_VEC    = DEF_NUM_VEC
) (
  input logic              clk,
  input logic              rst_n,
  vec_stream_mem_if.slave  bus
);

  localparam int DEPTH      = NUM_VEC * VEC_LEN;
  localparam int ADDR_WIDTH = clog2(DEPTH);
  localparam int VEC_WIDTH  = clog2(NUM_VEC);
  localparam int ELEM_WIDTH = clog2(VEC_LEN);
  localparam int ELEM_CNT_W = ELEM_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ELEM_CNT_W-1:0] LAST_ELEM = ELEM_CNT_W'(VEC_LEN - 1);
  localparam logic [ELEM_CNT_W-1:0] ELEM_END  = ELEM_CNT_W'(VEC_LEN);

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q,  init_cnt_d;
  logic [VEC_WIDTH-1:0]  vec_q,       vec_d;
  logic [ELEM_CNT_W-1:0] elem_q,      elem_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q,  out_last_d;
  logic                  busy_q,      busy_d;
  logic                  init_done_q, init_done_d;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Next-state logic: init sweep, request acceptance, read issue and the
  // write mux between the zero-fill and user writes. elem_q counts the
  // next element to issue and reaching VEC_LEN means nothing remains.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    vec_d       = vec_q;
    elem_d      = elem_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    ram_we      = 1'b0;
    ram_waddr   = bus.wr_addr;
    ram_wdata   = bus.wr_data;
    ram_re      = 1'b0;
    ram_raddr   = {vec_q, elem_q[ELEM_WIDTH-1:0]};

    case (state_q)
      INIT: begin
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdata  = '0;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      IDLE: begin
        ram_we = bus.wr_en;
        if (bus.rd_req) begin
          vec_d       = bus.rd_vec;
          ram_re      = 1'b1;
          ram_raddr   = {bus.rd_vec, {ELEM_WIDTH{1'b0}}};
          elem_d      = ELEM_CNT_W'(1);
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        ram_we = bus.wr_en;
        if (out_valid_q && bus.out_ready && out_last_q) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
        end else if ((!out_valid_q || bus.out_ready) && (elem_q < ELEM_END)) begin
          ram_re      = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (elem_q == LAST_ELEM);
          elem_d      = elem_q + ELEM_CNT_W'(1);
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State and output registers; reset restarts the zero-fill and drops
  // any stream in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      vec_q       <= '0;
      elem_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      vec_q       <= vec_d;
      elem_q      <= elem_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  vec_ram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = ram_rdata;
  assign bus.busy      = busy_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_vec_stream_mem.sv
// Testbench for vec_stream_mem: a behavioural memory/stream model checked
// every cycle, directed scenarios with literal expectations, and a
// randomized traffic phase.
module tb_vec_stream_mem;

  localparam int DW    = 8;
  localparam int VL    = 4;
  localparam int NV    = 4;
  localparam int DEPTH = VL * NV;
  localparam int AW    = 4;
  localparam int VW    = 2;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  bit   check_en = 0;

  vec_stream_mem_if #(.DATA_WIDTH(DW), .VEC_LEN(VL), .NUM_VEC(NV)) bus ();

  vec_stream_mem #(.DATA_WIDTH(DW), .VEC_LEN(VL), .NUM_VEC(NV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: memory contents plus the vector being streamed.
  // A write lands in the streamed copy only if that element has not yet
  // been read out of the RAM (reads are one per accepted beat, read-first).
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_exp [VL];
  int  m_init_left;
  bit  m_init_done;
  bit  m_busy;
  bit  m_stream;
  int  m_vec;
  int  m_acc;
  bit  t_start;
  int  t_addr;
  int  t_j;

  always @(posedge clk) begin : model
    if (!rst_n) begin
      m_init_left = DEPTH;
      m_init_done = 0;
      m_busy      = 1;
      m_stream    = 0;
      m_acc       = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (!m_init_done) begin
      m_init_left--;
      if (m_init_left == 0) begin
        m_init_done = 1;
        m_busy      = 0;
      end
    end else begin
      t_start = !m_stream && bus.rd_req;
      if (t_start) begin
        m_vec = int'(bus.rd_vec);
        m_acc = 0;
        for (int i = 0; i < VL; i++) m_exp[i] = m_mem[m_vec * VL + i];
      end
      if (bus.wr_en) begin
        t_addr = int'(bus.wr_addr);
        t_j    = t_addr % VL;
        if (t_addr / VL == m_vec) begin
          if (t_start) begin
            if (t_j >= 1) m_exp[t_j] = bus.wr_data;
          end else if (m_stream) begin
            if (t_j >= m_acc + 2 || (t_j == m_acc + 1 && !bus.out_ready))
              m_exp[t_j] = bus.wr_data;
          end
        end
        m_mem[t_addr] = bus.wr_data;
      end
      if (m_stream && bus.out_ready) begin
        m_acc++;
        if (m_acc == VL) begin
          m_stream = 0;
          m_busy   = 0;
        end
      end
      if (t_start) begin
        m_stream = 1;
        m_busy   = 1;
      end
    end
  end

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("busy", bus.busy, m_busy);
      checkOutput("init_done", bus.init_done, m_init_done);
      checkOutput("out_valid", bus.out_valid, m_stream);
      if (m_stream) begin
        checkOutput("out_data", bus.out_data, m_exp[m_acc]);
        checkOutput("out_last", bus.out_last, (m_acc == VL - 1));
      end else if (!m_init_done) begin
        checkOutput("out_data_init", bus.out_data, 0);
        checkOutput("out_last_init", bus.out_last, 0);
      end
    end
  end

  // Beats the DUT presents that will be accepted at the coming edge.
  logic [DW-1:0] seen [$];
  bit            seen_last [$];

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      seen.push_back(bus.out_data);
      seen_last.push_back(bus.out_last);
    end
  end

  task automatic applyStimulus(input bit we, input int addr, input int data,
                               input bit req, input int vec, input bit rdy);
    bus.wr_en     = we;
    bus.wr_addr   = addr[AW-1:0];
    bus.wr_data   = data[DW-1:0];
    bus.rd_req    = req;
    bus.rd_vec    = vec[VW-1:0];
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic waitInit(input bit poke, output int cycles);
    cycles = 0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (poke && i >= 3 && i < 8) applyStimulus(1, 2 * VL + 1, 8'h5A, 1, 2, 1);
      else                         applyStimulus(0, 0, 0, 0, 0, 1);
      cycles++;
      if (bus.init_done) break;
    end
  endtask

  // mode 0: ready held high; mode 1: ready toggles 1,0,0,1,1,0,1;
  // mode 2: write 0x99 to element 3 and fire ignored requests mid-stream.
  task automatic runStream(input int vec, input int mode, output int cycles);
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    bit rdy;
    bit timed_out;
    seen.delete();
    seen_last.delete();
    applyStimulus(0, 0, 0, 1, vec, 1);
    cycles    = 0;
    timed_out = 1;
    for (int i = 0; i < 64; i++) begin
      rdy = (mode == 1 && i < 7) ? pat[i] : 1'b1;
      if (mode == 2 && i == 0)     applyStimulus(1, vec * VL + 3, 8'h99, 1, 0, 1);
      else if (mode == 2 && i < 3) applyStimulus(0, 0, 0, 1, 3, 1);
      else                         applyStimulus(0, 0, 0, 0, 0, rdy);
      cycles++;
      if (!bus.busy) begin
        timed_out = 0;
        break;
      end
    end
    checkOutput("stream_timeout", timed_out, 0);
  endtask

  task automatic checkBeats(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_v [4];
    exp_v = '{e0, e1, e2, e3};
    checkOutput({tag, "_count"}, seen.size(), VL);
    for (int i = 0; i < VL; i++) begin
      if (i < seen.size()) begin
        checkOutput($sformatf("%s_beat%0d", tag, i), seen[i], exp_v[i]);
        checkOutput($sformatf("%s_last%0d", tag, i), seen_last[i], (i == VL - 1));
      end
    end
  endtask

  initial begin : stimulus
    int cyc;
    bit r_we, r_req, r_rdy;
    int r_addr, r_data, r_vec;

    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_vec    = '0;
    bus.out_ready = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 0);
    check_en = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Zero-fill timing, with requests and writes that must be ignored.
    seen.delete();
    waitInit(1, cyc);
    checkOutput("init_cycles", cyc, DEPTH);
    checkOutput("busy_after_init", bus.busy, 0);
    checkOutput("beats_during_init", seen.size(), 0);

    runStream(2, 0, cyc);
    checkBeats("zero_vec2", 8'h00, 8'h00, 8'h00, 8'h00);

    // Full-rate stream of a written vector.
    applyStimulus(1, VL + 0, 8'h11, 0, 0, 1);
    applyStimulus(1, VL + 1, 8'h22, 0, 0, 1);
    applyStimulus(1, VL + 2, 8'h33, 0, 0, 1);
    applyStimulus(1, VL + 3, 8'h44, 0, 0, 1);
    runStream(1, 0, cyc);
    checkBeats("vec1", 8'h11, 8'h22, 8'h33, 8'h44);
    checkOutput("vec1_cycles", cyc, VL);

    // Backpressure.
    runStream(1, 1, cyc);
    checkBeats("stall", 8'h11, 8'h22, 8'h33, 8'h44);
    checkOutput("stall_cycles", cyc, 7);

    // Write ahead of the read, plus ignored mid-stream requests.
    runStream(1, 2, cyc);
    checkBeats("midwr", 8'h11, 8'h22, 8'h33, 8'h99);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("no_requeue_busy", bus.busy, 0);

    // Reset on beat 2 of a stream.
    applyStimulus(1, 3 * VL + 0, 8'hA1, 0, 0, 1);
    applyStimulus(1, 3 * VL + 1, 8'hB2, 0, 0, 1);
    applyStimulus(1, 3 * VL + 2, 8'hC3, 0, 0, 1);
    applyStimulus(1, 3 * VL + 3, 8'hD4, 0, 0, 1);
    seen.delete();
    seen_last.delete();
    applyStimulus(0, 0, 0, 1, 3, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("valid_after_reset", bus.out_valid, 0);
    checkOutput("init_done_after_reset", bus.init_done, 0);
    checkOutput("beats_before_reset", seen.size(), 2);
    rst_n = 1'b1;
    waitInit(0, cyc);
    checkOutput("reinit_cycles", cyc, DEPTH);
    runStream(3, 0, cyc);
    checkBeats("zero_vec3", 8'h00, 8'h00, 8'h00, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r_we   = ($urandom_range(0, 1) == 1);
      r_addr = int'($urandom_range(0, DEPTH - 1));
      r_data = int'($urandom_range(0, 255));
      r_req  = ($urandom_range(0, 3) == 0);
      r_vec  = int'($urandom_range(0, NV - 1));
      r_rdy  = ($urandom_range(0, 9) < 7);
      applyStimulus(r_we, r_addr, r_data, r_req, r_vec, r_rdy);
    end
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("drain_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
